// File: rtl/host_bus_initiator_if.sv
// Slave-bus bundle between host_bus_initiator (master side) and a monitor-card slave.
interface host_bus_initiator_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              CARDSEL;
  logic              WR_N;
  logic [ADDR_W-1:0] AI;
  logic [DATA_W-1:0] SDI;
  logic              SACK_N;
  logic [DATA_W-1:0] SDO;

  modport master (output CARDSEL, WR_N, AI, SDI, input SACK_N, SDO);
  modport slave  (input CARDSEL, WR_N, AI, SDI, output SACK_N, SDO);
endinterface

// File: rtl/host_bus_initiator.sv
// Four-phase slave-bus initiator: one transaction in flight, timeout on a dead slave.
// Optional SACK_SYNC_EN: SACK_N passes through a two-flop synchronizer before the FSM.
module host_bus_initiator #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int SETUP_CYC   = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   rdata,
  output logic                timeout_err,
  host_bus_initiator_if.master bus
);

  localparam int SC_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam int WC_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SC_W-1:0] SETUP_LAST = SC_W'(SETUP_CYC - 1);
  localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ASSERT  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e            state_r, state_nxt_s;
  logic [SC_W-1:0]   setup_cnt_r, setup_cnt_nxt_s;
  logic [WC_W-1:0]   wait_cnt_r, wait_cnt_nxt_s;
  logic              cardsel_r, cardsel_nxt_s;
  logic              wr_n_r, wr_n_nxt_s;
  logic [ADDR_W-1:0] ai_r, ai_nxt_s;
  logic [DATA_W-1:0] sdi_r, sdi_nxt_s;
  logic [DATA_W-1:0] rdata_r, rdata_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              done_r, done_nxt_s;
  logic              terr_r, terr_nxt_s;
  logic              ack_s;

`ifdef SACK_SYNC_EN
  logic sack_meta_r, sack_sync_r;

  // Two-flop synchronizer for the slave acknowledge; idles deasserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sack_meta_r <= 1'b1;
      sack_sync_r <= 1'b1;
    end else begin
      sack_meta_r <= bus.SACK_N;
      sack_sync_r <= sack_meta_r;
    end
  end

  assign ack_s = ~sack_sync_r;
`else
  assign ack_s = ~bus.SACK_N;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt_s     = state_r;
    setup_cnt_nxt_s = setup_cnt_r;
    wait_cnt_nxt_s  = wait_cnt_r;
    cardsel_nxt_s   = cardsel_r;
    wr_n_nxt_s      = wr_n_r;
    ai_nxt_s        = ai_r;
    sdi_nxt_s       = sdi_r;
    rdata_nxt_s     = rdata_r;
    busy_nxt_s      = busy_r;
    done_nxt_s      = 1'b0;
    terr_nxt_s      = terr_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          state_nxt_s     = ST_SETUP;
          setup_cnt_nxt_s = {SC_W{1'b0}};
          ai_nxt_s        = req_addr;
          sdi_nxt_s       = req_wdata;
          wr_n_nxt_s      = ~req_wr;
          terr_nxt_s      = 1'b0;
          busy_nxt_s      = 1'b1;
          cardsel_nxt_s   = 1'b0;
        end else begin
          busy_nxt_s      = 1'b0;
        end
      end
      ST_SETUP: begin
        if (setup_cnt_r == SETUP_LAST) begin
          state_nxt_s    = ST_ASSERT;
          cardsel_nxt_s  = 1'b1;
          wait_cnt_nxt_s = {WC_W{1'b0}};
        end else begin
          setup_cnt_nxt_s = setup_cnt_r + 1'b1;
        end
      end
      ST_ASSERT: begin
        // An ack already present on entry is taken on the first edge: level, not edge, sensitive.
        if (ack_s) begin
          if (wr_n_r) begin
            rdata_nxt_s = bus.SDO;
          end else begin
            rdata_nxt_s = rdata_r;
          end
          state_nxt_s    = ST_RELEASE;
          cardsel_nxt_s  = 1'b0;
          wait_cnt_nxt_s = {WC_W{1'b0}};
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s   = ST_DONE;
          cardsel_nxt_s = 1'b0;
          terr_nxt_s    = 1'b1;
          done_nxt_s    = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          state_nxt_s = ST_DONE;
          done_nxt_s  = 1'b1;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s = ST_DONE;
          terr_nxt_s  = 1'b1;
          done_nxt_s  = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
        wr_n_nxt_s  = 1'b1;
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        cardsel_nxt_s = 1'b0;
        busy_nxt_s    = 1'b0;
        wr_n_nxt_s    = 1'b1;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      setup_cnt_r <= {SC_W{1'b0}};
      wait_cnt_r  <= {WC_W{1'b0}};
      cardsel_r   <= 1'b0;
      wr_n_r      <= 1'b1;
      ai_r        <= {ADDR_W{1'b0}};
      sdi_r       <= {DATA_W{1'b0}};
      rdata_r     <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      terr_r      <= 1'b0;
    end else begin
      setup_cnt_r <= setup_cnt_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      cardsel_r   <= cardsel_nxt_s;
      wr_n_r      <= wr_n_nxt_s;
      ai_r        <= ai_nxt_s;
      sdi_r       <= sdi_nxt_s;
      rdata_r     <= rdata_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      terr_r      <= terr_nxt_s;
    end
  end

  assign bus.CARDSEL = cardsel_r;
  assign bus.WR_N    = wr_n_r;
  assign bus.AI      = ai_r;
  assign bus.SDI     = sdi_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign rdata       = rdata_r;
  assign timeout_err = terr_r;

endmodule

// File: tb/tb_host_bus_initiator.sv
// Bench for host_bus_initiator: behavioural slave, table vectors, random traffic vs. memory model.
module tb_host_bus_initiator;

`ifdef SACK_SYNC_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req, req_wr;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        busy, done, timeout_err;
  logic [31:0] rdata;

  host_bus_initiator_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  host_bus_initiator dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .done(done), .rdata(rdata),
    .timeout_err(timeout_err), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Slave: mode 0 = normal (ack ack_dly cycles after CARDSEL), 1 = never acks, 2 = ack stuck low
  int          ack_dly = 0;
  int          slave_mode = 0;
  bit          stuck_r;
  int          hi_cnt = 0;
  bit          sdo_force = 1'b0;
  logic [31:0] sdo_force_val = 32'h0;
  logic [31:0] slv_mem [0:1023];
  bit          slv_valid [0:1023];
  logic        cs_q = 1'b0;
  int          cs_rises = 0;
  int          done_cnt = 0;

  function automatic logic [31:0] pat(input logic [9:0] a);
    return {6'h2A, a, ~a, 6'h15};
  endfunction

  always @(posedge clk) begin
    hi_cnt <= bus.CARDSEL ? hi_cnt + 1 : 0;
    if (slave_mode == 2 && !bus.SACK_N) stuck_r <= 1'b1;
    else if (slave_mode != 2) stuck_r <= 1'b0;
    if (bus.CARDSEL && !bus.SACK_N && !bus.WR_N) begin
      slv_mem[bus.AI]   <= bus.SDI;
      slv_valid[bus.AI] <= 1'b1;
    end
    cs_q <= bus.CARDSEL;
    if (bus.CARDSEL && !cs_q) cs_rises <= cs_rises + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  assign bus.SACK_N = stuck_r ? 1'b0 : (slave_mode == 1) ? 1'b1 :
                      !(bus.CARDSEL && hi_cnt >= ack_dly);
  assign bus.SDO = sdo_force ? sdo_force_val :
                   (slv_valid[bus.AI] ? slv_mem[bus.AI] : pat(bus.AI));

  // Reference model: what each address holds from the host's point of view
  logic [31:0] model_mem [int];
  logic [31:0] model_rdata;

  function automatic logic [31:0] model_rd(input logic [9:0] a);
    if (model_mem.exists(int'(a))) return model_mem[int'(a)];
    return pat(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One transaction; exp_lat = edges after the accepting edge at which done is sampled high
  task automatic run_txn(input bit wr, input logic [9:0] a, input logic [31:0] d, input int dly,
                         input int exp_lat, input int exp_cs, input bit exp_terr,
                         input logic [31:0] exp_rd, input string tag);
    int k, cs;
    bit bad;
    @(negedge clk);
    req = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; ack_dly = dly;
    @(posedge clk); #1;
    req = 1'b0;
    chk({tag, "_busy_accept"}, 64'(busy), 64'd1);
    chk({tag, "_terr_clear"}, 64'(timeout_err), 64'd0);
    k = 0; cs = 0; bad = 1'b0;
    while (!done && k < 600) begin
      if (bus.CARDSEL) cs++;
      if (bus.AI !== a || bus.WR_N !== ~wr || bus.SDI !== d || !busy) bad = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_latency"}, 64'(k + 1), 64'(exp_lat));
    chk({tag, "_cs_cycles"}, 64'(cs), 64'(exp_cs));
    chk({tag, "_bus_stable"}, 64'(bad), 64'd0);
    chk({tag, "_terr"}, 64'(timeout_err), 64'(exp_terr));
    chk({tag, "_rdata"}, 64'(rdata), 64'(exp_rd));
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, {62'd0, busy, bus.WR_N}, 64'd1);
    chk({tag, "_hold"}, {22'd0, bus.AI, bus.SDI}, {22'd0, a, d});
  endtask

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          dly;
    bit          force_sdo;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_cs;
  } vec_t;

  vec_t vtab [5];

  initial begin
    int k, r0, d0;
    vtab[0] = '{1'b0, 10'h005, 32'h1111_2222, 3, 1'b1, 32'hDEAD_BEEF, 7 + 4*S, 4 + 2*S};
    vtab[1] = '{1'b1, 10'h3FF, 32'h0000_00A5, 0, 1'b0, 32'hDEAD_BEEF, 4 + 4*S, 1 + 2*S};
    vtab[2] = '{1'b0, 10'h3FF, 32'h3333_4444, 0, 1'b0, 32'h0000_00A5, 4 + 4*S, 1 + 2*S};
    vtab[3] = '{1'b1, 10'h000, 32'h1234_5678, 1, 1'b0, 32'h0000_00A5, 5 + 4*S, 2 + 2*S};
    vtab[4] = '{1'b0, 10'h000, 32'h5555_6666, 2, 1'b0, 32'h1234_5678, 6 + 4*S, 3 + 2*S};

    reset = 1'b0; req = 1'b0; req_wr = 1'b0; req_addr = 10'h0; req_wdata = 32'h0;
    #12;
    chk("rst_bus", {22'd0, bus.CARDSEL, bus.WR_N, bus.AI, bus.SDI},
        {22'd0, 1'b0, 1'b1, 10'h000, 32'h0});
    chk("rst_status", {29'd0, busy, done, timeout_err, rdata}, 64'd0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      sdo_force = vtab[i].force_sdo; sdo_force_val = 32'hDEAD_BEEF;
      run_txn(vtab[i].wr, vtab[i].addr, vtab[i].wdata, vtab[i].dly, vtab[i].exp_lat,
              vtab[i].exp_cs, 1'b0, vtab[i].exp_rdata, $sformatf("vec%0d", i));
      if (vtab[i].wr) model_mem[int'(vtab[i].addr)] = vtab[i].wdata;
    end
    sdo_force = 1'b0;
    model_rdata = 32'h1234_5678;

    // Dead slave: CARDSEL held for the full timeout, rdata untouched
    slave_mode = 1;
    run_txn(1'b0, 10'h055, 32'h0BAD_0001, 0, 257, 255, 1'b1, model_rdata, "to_never");
    // Slave acks then never releases: timeout in RELEASE, read data still captured
    slave_mode = 2;
    model_rdata = model_rd(10'h0AA);
    run_txn(1'b0, 10'h0AA, 32'h0BAD_0002, 0, 258 + 2*S, 1 + 2*S, 1'b1, model_rdata, "to_stuck");
    slave_mode = 0;
    repeat (5) @(posedge clk);

    // req pulsed mid-transaction must not start a second bus cycle
    r0 = cs_rises;
    fork
      run_txn(1'b1, 10'h021, 32'hCAFE_0021, 3, 7 + 4*S, 4 + 2*S, 1'b0, model_rdata, "busy_req");
      begin
        repeat (3) @(negedge clk);
        req = 1'b1; req_addr = 10'h1F0; req_wr = 1'b1; req_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        req = 1'b0;
      end
    join
    model_mem[int'(10'h021)] = 32'hCAFE_0021;
    repeat (2) @(posedge clk);
    chk("busy_req_one_txn", 64'(cs_rises - r0), 64'd1);

    // req held high: accepted again only after one IDLE cycle
    r0 = cs_rises;
    @(negedge clk);
    req = 1'b1; req_wr = 1'b0; req_addr = 10'h021; req_wdata = 32'h0; ack_dly = 0;
    @(posedge clk); #1;
    k = 0;
    while (!done && k < 600) begin @(posedge clk); #1; k++; end
    chk("b2b_lat1", 64'(k + 1), 64'(4 + 4*S));
    @(posedge clk); #1;
    chk("b2b_gap_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("b2b_reaccept", 64'(busy), 64'd1);
    req = 1'b0;
    k = 0;
    while (!done && k < 600) begin @(posedge clk); #1; k++; end
    chk("b2b_lat2", 64'(k + 1), 64'(4 + 4*S));
    repeat (2) @(posedge clk); #1;
    chk("b2b_two_txn", 64'(cs_rises - r0), 64'd2);
    chk("b2b_rdata", 64'(rdata), 64'(32'hCAFE_0021));
    model_rdata = 32'hCAFE_0021;

    // Randomized traffic against the memory model
    for (int i = 0; i < 40; i++) begin
      bit          wr;
      logic [9:0]  a;
      logic [31:0] d;
      int          dly;
      wr  = 1'($urandom_range(0, 1));
      a   = 10'($urandom_range(0, 15));
      d   = $urandom;
      dly = $urandom_range(0, 4);
      if (!wr) model_rdata = model_rd(a);
      run_txn(wr, a, d, dly, 4 + dly + 4*S, 1 + dly + 2*S, 1'b0, model_rdata,
              $sformatf("rnd%0d", i));
      if (wr) model_mem[int'(a)] = d;
    end

    // Asynchronous reset while CARDSEL is high
    ack_dly = 20;
    @(negedge clk);
    req = 1'b1; req_wr = 1'b0; req_addr = 10'h007; req_wdata = 32'h0;
    @(posedge clk); #1;
    req = 1'b0;
    k = 0;
    while (!bus.CARDSEL && k < 20) begin @(posedge clk); #1; k++; end
    chk("rst_mid_cs_high", 64'(bus.CARDSEL), 64'd1);
    repeat (2) @(posedge clk);
    #3;
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    chk("rst_mid_cs_drop", {62'd0, bus.CARDSEL, busy}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    chk("rst_mid_state", {22'd0, bus.WR_N, bus.AI, rdata, timeout_err},
        {22'd0, 1'b1, 10'h000, 32'h0, 1'b0});
    ack_dly = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
